id_operand_stage: RTL
=====================

// Module: id_operand_stage
// PURPOSE
//  Parametrised decode/operand stage: owns the architectural register file, resolves both source operands
//  through a priority forwarding network (EX > MEM > WB > regfile), detects load-use hazards and holds the
//  ID/EX pipeline register under a valid/ready handshake with flush. Sits between IF/decode and EX.
// PARAMETERS
//  XLEN      64   datapath / register width
//  CTRL_W    16   width of opaque control bundle passed through to EX
//  NREG      32   architectural registers (index width RAW = $clog2(NREG)); register 0 reads as zero
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       upstream instruction valid
//  in_ready     out  1       stage can accept this cycle
//  in_pc        in   XLEN    instruction PC
//  in_ins       in   32      raw instruction (passed through)
//  in_rs1/rs2   in   RAW     source register indices
//  in_use_rs1/2 in   1       instruction actually reads rs1/rs2
//  in_rd        in   RAW     destination index
//  in_rd_we     in   1       instruction writes rd
//  in_is_load   in   1       instruction is a load
//  in_imm       in   XLEN    pre-extended immediate
//  in_src1_sel  in   2       0 rs1, 1 pc, 2 zero
//  in_src2_sel  in   2       0 rs2, 1 imm, 2 constant 4
//  in_ctrl      in   CTRL_W  control bundle
//  ex_we/ex_is_load in 1     EX-stage writeback enable / EX holds a load
//  ex_rd,ex_data    in RAW,XLEN  EX destination and result
//  mem_we,mem_rd,mem_data in 1,RAW,XLEN   MEM-stage forward source
//  wb_we,wb_rd,wb_data    in 1,RAW,XLEN   WB write port (also forward source)
//  flush        in   1       kill instruction in ID/EX register
//  jr_target    out  XLEN    (fwd_rs1 + in_imm) & ~1, combinational, for jalr redirect
//  out_valid    out  1       ID/EX register valid
//  out_ready    in   1       EX accepts
//  out_pc,out_ins,out_ctrl,out_rd,out_rd_we,out_is_load   registered pass-through
//  out_src_a,out_src_b,out_rs2_data  out XLEN  resolved operands; rs2_data for stores
// BEHAVIOUR
//  - Forward per operand: idx==0 -> 0; else ex_we&&ex_rd==idx&&!ex_is_load -> ex_data;
//    else mem match -> mem_data; else wb match -> wb_data; else regfile[idx]. Matches need *_we=1.
//  - Hazard = ex_we & ex_is_load & ex_rd!=0 & ((in_use_rs1&rs1==ex_rd)|(in_use_rs2&rs2==ex_rd)) & in_valid.
//  - adv = !out_valid | out_ready. in_ready = adv & !hazard.
//  - Each edge, priority: reset > flush > adv. flush: out_valid<=0. adv & in_valid & !hazard: load payload,
//    out_valid<=1. adv & (hazard | !in_valid): out_valid<=0 (bubble). !adv: hold all outputs.
//  - Regfile write wb_we & wb_rd!=0 every cycle regardless of stall/flush; same-cycle read gets wb_data
//    via forward path (no read-before-write hazard).
//  - Latency 1 cycle in->out; full throughput when no hazard; load-use costs exactly 1 bubble.
//  - Reset: out_valid 0, all out_* payload 0, regfile all 0. Reset mid-stall drops held instruction.
//  - Arithmetic mod 2^XLEN; src2 constant 4 zero-extended.
// CONFIGURATION
//  ID_PERF_CNT_EN defined: adds outputs perf_stall_cnt, perf_bubble_cnt (32 b each, reset 0, saturate at
//  all-ones); stall_cnt +1 per cycle hazard=1, bubble_cnt +1 per bubble inserted by hazard.
//  Undefined: ports and counters absent; otherwise identical behaviour.
// TESTING
//  1 reset, then addi x5,x0,7 (imm=7, src2=imm) -> next cycle out_valid=1, src_a=0, src_b=7.
//  2 ex_we=1,ex_rd=5,ex_data=0x11; mem_rd=5,mem_data=0x22; in_rs1=5 -> out_src_a=0x11 (EX wins).
//  3 ex load to x6, in uses rs2=6 -> in_ready=0 one cycle, out_valid=0 bubble, next cycle accepted.
//  4 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> advances.
//  5 flush while in_valid=1, adv=1 -> out_valid=0 next cycle; wb write x7=0xAB still lands in regfile.
//  6 wb_we=1,wb_rd=0,wb_data=0xFF then read x0 -> 0; rs1=3 wb_rd=3 same cycle -> src_a=wb_data.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode/operand stage: register file, EX>MEM>WB forwarding, load-use hazard detection and
// the ID/EX pipeline register. Define ID_PERF_CNT_EN to add the stall/bubble counters.
module id_operand_stage #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned NREG   = 32,
    localparam int unsigned RAW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_ins,
    input  logic [RAW-1:0]    in_rs1,
    input  logic [RAW-1:0]    in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [RAW-1:0]    in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [1:0]        in_src1_sel,
    input  logic [1:0]        in_src2_sel,
    input  logic [CTRL_W-1:0] in_ctrl,

    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [RAW-1:0]    ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_we,
    input  logic [RAW-1:0]    mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [RAW-1:0]    wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    input  logic              flush,
    output logic [XLEN-1:0]   jr_target,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_ins,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RAW-1:0]    out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [XLEN-1:0]   out_src_a,
    output logic [XLEN-1:0]   out_src_b,
    output logic [XLEN-1:0]   out_rs2_data
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic [XLEN-1:0] rf_q [NREG];

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] jr_sum;
    logic            hazard;
    logic            adv;
    logic            load_en;

    // A load in EX has no data yet, so it is never a forward source.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RAW-1:0]  idx,
        input logic [XLEN-1:0] rf_val,
        input logic            f_ex_we,
        input logic            f_ex_is_load,
        input logic [RAW-1:0]  f_ex_rd,
        input logic [XLEN-1:0] f_ex_data,
        input logic            f_mem_we,
        input logic [RAW-1:0]  f_mem_rd,
        input logic [XLEN-1:0] f_mem_data,
        input logic            f_wb_we,
        input logic [RAW-1:0]  f_wb_rd,
        input logic [XLEN-1:0] f_wb_data
    );
        logic [XLEN-1:0] val;
        if (idx == '0) begin
            val = '0;
        end else if (f_ex_we && f_ex_rd == idx && !f_ex_is_load) begin
            val = f_ex_data;
        end else if (f_mem_we && f_mem_rd == idx) begin
            val = f_mem_data;
        end else if (f_wb_we && f_wb_rd == idx) begin
            val = f_wb_data;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    always_comb begin
        fwd_rs1 = resolve(in_rs1, rf_q[in_rs1], ex_we, ex_is_load, ex_rd, ex_data,
                          mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
        fwd_rs2 = resolve(in_rs2, rf_q[in_rs2], ex_we, ex_is_load, ex_rd, ex_data,
                          mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
    end

    always_comb begin
        src_a = '0;
        unique case (in_src1_sel)
            2'd0:    src_a = fwd_rs1;
            2'd1:    src_a = in_pc;
            default: src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        unique case (in_src2_sel)
            2'd0:    src_b = fwd_rs2;
            2'd1:    src_b = in_imm;
            2'd2:    src_b = XLEN'(4);
            default: src_b = '0;
        endcase
    end

    always_comb begin
        jr_sum    = fwd_rs1 + in_imm;
        jr_target = {jr_sum[XLEN-1:1], 1'b0};
    end

    always_comb begin
        hazard   = in_valid && ex_we && ex_is_load && (ex_rd != '0) &&
                   ((in_use_rs1 && in_rs1 == ex_rd) || (in_use_rs2 && in_rs2 == ex_rd));
        adv      = !out_valid || out_ready;
        in_ready = adv && !hazard;
        load_en  = adv && in_valid && !hazard;
    end

    // Write port is independent of stall/flush; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && wb_rd != '0) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_ins      <= '0;
            out_ctrl     <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            out_is_load  <= 1'b0;
            out_src_a    <= '0;
            out_src_b    <= '0;
            out_rs2_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= load_en;
            if (load_en) begin
                out_pc       <= in_pc;
                out_ins      <= in_ins;
                out_ctrl     <= in_ctrl;
                out_rd       <= in_rd;
                out_rd_we    <= in_rd_we;
                out_is_load  <= in_is_load;
                out_src_a    <= src_a;
                out_src_b    <= src_b;
                out_rs2_data <= fwd_rs2;
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    // A hazard only becomes a bubble when the register actually advances and no flush wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (hazard && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (hazard && adv && !flush && perf_bubble_cnt != '1) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
